// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, the transmit-side partner of the link's receiver.
// It sends one parallel word per request as a frame: a start bit (0), the data
// bits LSB first, an optional parity bit, then the stop bit(s) (1). It runs on
// the same oversampled baud clock as the receiver and holds each bit on the
// line for OVERSAMPLING ticks.
module uart_tx #(
  parameter int NUM_DATA_BITS = 8,
  parameter int OVERSAMPLING  = 16,
  parameter int PARITY_MODE   = 1,
  parameter int NUM_STOP_BITS = 1
) (
  input  logic                     baud,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [NUM_DATA_BITS-1:0] data_in,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state
);

  // State encodings. The three unused codes fall back to IDLE.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // The tick counter spans one bit time. The bit counter indexes data bits
  // and, later in the frame, stop bits.
  localparam int TICK_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int CNT_W  = $clog2(NUM_DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLING - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(NUM_DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST  = CNT_W'(NUM_STOP_BITS - 1);
  localparam bit                HAS_PARITY = (PARITY_MODE != 0);

  logic [2:0]               r_state;
  logic [TICK_W-1:0]        r_tick;
  logic [CNT_W-1:0]         r_bitCnt;
  logic [NUM_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic                     r_tx;
  logic                     r_done;

  logic w_bitEnd;
  logic w_parity;

  // Bit-boundary detection, and the parity of the word being offered for acceptance.
  always_comb begin
    w_bitEnd = (r_tick == TICK_LAST);
    if (PARITY_MODE == 2) begin
      w_parity = ~^data_in;
    end else begin
      w_parity = ^data_in;
    end
  end

  // Frame sequencer. tx is registered, so the start bit goes out on the
  // accepting edge itself. Dropping enable forces an immediate return to idle.
  always_ff @(posedge baud or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else if (!enable) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitCnt <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx     <= 1'b1;
          r_tick   <= '0;
          r_bitCnt <= '0;
          if (start) begin
            r_shift  <= data_in;
            r_parity <= w_parity;
            r_state  <= S_START;
            r_tx     <= 1'b0;
          end
        end
        S_START: begin
          if (w_bitEnd) begin
            r_tick   <= '0;
            r_bitCnt <= '0;
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_state  <= S_DATA;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            r_tick <= '0;
            if (r_bitCnt == DATA_LAST) begin
              r_bitCnt <= '0;
              if (HAS_PARITY) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + CNT_W'(1);
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bitEnd) begin
            r_tick   <= '0;
            r_bitCnt <= '0;
            r_tx     <= 1'b1;
            r_state  <= S_STOP;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bitEnd) begin
            r_tick <= '0;
            if (r_bitCnt == STOP_LAST) begin
              r_bitCnt <= '0;
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tick   <= '0;
          r_bitCnt <= '0;
          r_tx     <= 1'b1;
        end
      endcase
    end
  end

  // Status outputs. busy is derived from the state so that it can never
  // disagree with it.
  always_comb begin
    ready = (r_state == S_IDLE) && enable && !reset;
    busy  = (r_state != S_IDLE);
    tx    = r_tx;
    done  = r_done;
    state = r_state;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. The stimulus pushes hand-computed
// expected frames into a queue. A negedge monitor decodes the tx line as a
// receiver would and checks each finished frame against the queue.
module tb_uart_tx;

  localparam int OS        = 16;
  localparam int FRAME_LEN = 176;

  logic       baud  = 1'b0;
  logic       reset = 1'b0;
  logic       enable;
  logic       start;
  logic [7:0] data_in;
  logic       ready, tx, busy, done;
  logic [2:0] state;

  logic       startOdd, readyOdd, txOdd, busyOdd, doneOdd;
  logic [7:0] dataOdd;
  logic [2:0] stateOdd;
  logic       startNone, readyNone, txNone, busyNone, doneNone;
  logic [7:0] dataNone;
  logic [2:0] stateNone;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         abort;
    bit         gap;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   edgeCount   = 0;

  // Main DUT: 8 data bits, even parity, 1 stop bit.
  uart_tx #(.NUM_DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_MODE(1), .NUM_STOP_BITS(1)) dut (
    .baud(baud), .reset(reset), .enable(enable), .start(start), .data_in(data_in),
    .ready(ready), .tx(tx), .busy(busy), .done(done), .state(state)
  );

  // Odd-parity instance.
  uart_tx #(.NUM_DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_MODE(2), .NUM_STOP_BITS(1)) dutOdd (
    .baud(baud), .reset(reset), .enable(enable), .start(startOdd), .data_in(dataOdd),
    .ready(readyOdd), .tx(txOdd), .busy(busyOdd), .done(doneOdd), .state(stateOdd)
  );

  // No-parity instance.
  uart_tx #(.NUM_DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_MODE(0), .NUM_STOP_BITS(1)) dutNone (
    .baud(baud), .reset(reset), .enable(enable), .start(startNone), .data_in(dataNone),
    .ready(readyNone), .tx(txNone), .busy(busyNone), .done(doneNone), .state(stateNone)
  );

  // 10-unit baud clock.
  always #5 baud = ~baud;

  // Absolute edge counter used to time frames.
  always @(posedge baud) edgeCount <= edgeCount + 1;

  // Records one comparison and reports it if it failed.
  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endfunction

  // Records a failure that has no value pair, such as a timeout or an unexpected frame.
  function automatic void failNow(string name, string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: %s", name, what);
  endfunction

  bit         monActive = 0;
  bit         monIgnore = 0;
  bit         levelErr  = 0;
  exp_t       cur;
  int         acceptEdge = 0;
  int         prevAccept = 0;
  int         k, bitIdx, firstErrK;
  logic [7:0] decoded;
  logic       decPar, decStop, expLvl;

  // Monitor: decodes each frame at mid-bit and checks every tick's level
  // against the frame expected from the queue.
  initial begin
    forever begin
      @(negedge baud);
      checkOutput("busy_state", busy, state != 3'd0);
      checkOutput("done_busy_excl", done && busy, 1'b0);
      if (monActive) begin
        k = edgeCount - acceptEdge;
        if (reset || (!busy && !done)) begin
          if (!monIgnore) checkOutput("abort_expected", 1'b1, cur.abort);
          monActive = 0;
        end else if (done) begin
          if (!monIgnore) begin
            checkOutput("frame_len", k, FRAME_LEN);
            checkOutput("rx_data", decoded, cur.data);
            checkOutput("rx_parity", decPar, cur.par);
            checkOutput("rx_stop", decStop, 1'b1);
            checkOutput("level_err_at_tick", levelErr ? firstErrK : -1, -1);
            checkOutput("abort_expected", 1'b0, cur.abort);
          end
          monActive = 0;
        end else begin
          bitIdx = k / OS;
          if (bitIdx == 0) expLvl = 1'b0;
          else if (bitIdx <= 8) expLvl = cur.data[bitIdx-1];
          else if (bitIdx == 9) expLvl = cur.par;
          else expLvl = 1'b1;
          if (!monIgnore && !levelErr && tx !== expLvl) begin
            levelErr  = 1;
            firstErrK = k;
          end
          if (k % OS == OS / 2) begin
            if (bitIdx >= 1 && bitIdx <= 8) decoded[bitIdx-1] = tx;
            else if (bitIdx == 9) decPar = tx;
            else if (bitIdx == 10) decStop = tx;
          end
        end
      end else if (!reset && busy) begin
        if (expQ.size() == 0) begin
          failNow("unexpected_frame", "frame started, required idle");
          monIgnore = 1;
        end else begin
          cur = expQ.pop_front();
          monIgnore = 0;
          if (cur.gap) checkOutput("b2b_gap", edgeCount - prevAccept, 177);
        end
        monActive  = 1;
        acceptEdge = edgeCount;
        prevAccept = edgeCount;
        levelErr   = 0;
        decoded    = '0;
        decPar     = 1'bx;
        decStop    = 1'bx;
        if (!monIgnore && tx !== 1'b0) begin
          levelErr  = 1;
          firstErrK = 0;
        end
      end else begin
        checkOutput("idle_done", done, 1'b0);
      end
    end
  end

  // Waits, with a cycle budget, for the main DUT to become ready.
  task automatic waitReady(int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge baud);
      n++;
    end
    if (!ready) failNow("ready_timeout", "ready never rose");
  endtask

  // Waits, with a cycle budget, for the main DUT's done pulse.
  task automatic waitDone(int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge baud);
      n++;
    end
    if (!done) failNow("done_timeout", "done never pulsed");
  endtask

  // Offers one word to the main DUT and queues its expected frame. Returns at
  // the negedge that follows the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input logic par, input bit abort);
    waitReady(500);
    data_in = d;
    start   = 1'b1;
    expQ.push_back('{data: d, par: par, abort: abort, gap: 0});
    @(negedge baud);
    start = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int n;
    enable    = 1'b1;
    start     = 1'b0;
    data_in   = '0;
    startOdd  = 1'b0;
    dataOdd   = '0;
    startNone = 1'b0;
    dataNone  = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge baud);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_state", state, 3'd0);
    checkOutput("reset_ready", ready, 1'b0);
    reset = 1'b0;
    @(negedge baud);
    checkOutput("post_reset_ready", ready, 1'b1);

    // Asynchronous reset in the middle of the data bits.
    applyStimulus(8'hC3, 1'b0, 1);
    repeat (53) @(negedge baud);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_done", done, 1'b0);
    checkOutput("midreset_state", state, 3'd0);
    @(negedge baud);
    reset = 1'b0;
    repeat (20) @(negedge baud);
    checkOutput("after_reset_state", state, 3'd0);
    checkOutput("after_reset_tx", tx, 1'b1);

    // Default frame, then an even-parity check with 8'h07.
    applyStimulus(8'hA5, 1'b0, 0);
    waitDone(400);
    applyStimulus(8'h07, 1'b1, 0);
    waitDone(400);
    @(negedge baud);

    // Odd parity: 8'h07 has an odd number of ones, so the parity bit is 0.
    n = 0;
    while (!readyOdd && n < 100) begin @(negedge baud); n++; end
    dataOdd  = 8'h07;
    startOdd = 1'b1;
    @(negedge baud);
    startOdd = 1'b0;
    repeat (152) @(negedge baud);
    checkOutput("odd_parity_bit", txOdd, 1'b0);
    n = 152;
    while (!doneOdd && n < 400) begin @(negedge baud); n++; end
    checkOutput("odd_frame_len", n, 176);

    // No parity: the stop bit follows the last data bit and the frame is 160 edges long.
    n = 0;
    while (!readyNone && n < 100) begin @(negedge baud); n++; end
    dataNone  = 8'h03;
    startNone = 1'b1;
    @(negedge baud);
    startNone = 1'b0;
    repeat (152) @(negedge baud);
    checkOutput("none_stop_after_data", txNone, 1'b1);
    n = 152;
    while (!doneNone && n < 400) begin @(negedge baud); n++; end
    checkOutput("none_frame_len", n, 160);
    @(negedge baud);

    // Back-to-back with start held high. data_in changes mid-frame.
    waitReady(500);
    data_in = 8'h00;
    start   = 1'b1;
    expQ.push_back('{data: 8'h00, par: 1'b0, abort: 0, gap: 0});
    @(negedge baud);
    data_in = 8'hFF;
    expQ.push_back('{data: 8'hFF, par: 1'b0, abort: 0, gap: 1});
    waitDone(400);
    @(negedge baud);
    start = 1'b0;
    checkOutput("b2b_second_busy", busy, 1'b1);
    waitDone(400);
    @(negedge baud);

    // Abort by dropping enable so that edge 50 of the frame sees it low.
    applyStimulus(8'hF0, 1'b0, 1);
    repeat (49) @(negedge baud);
    enable = 1'b0;
    @(negedge baud);
    checkOutput("abort_tx", tx, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_state", state, 3'd0);
    start = 1'b1;
    @(negedge baud);
    checkOutput("disabled_no_accept", busy, 1'b0);
    start  = 1'b0;
    enable = 1'b1;
    repeat (200) @(negedge baud);
    applyStimulus(8'h3C, 1'b0, 0);
    waitDone(400);
    @(negedge baud);

    // start during a frame is ignored.
    applyStimulus(8'h55, 1'b0, 0);
    repeat (60) @(negedge baud);
    data_in = 8'h11;
    start   = 1'b1;
    @(negedge baud);
    start = 1'b0;
    waitDone(400);
    repeat (250) @(negedge baud);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog for a stuck run.
  initial begin
    #500000;
    failNow("global_timeout", "simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
